// File: rtl/i2c_phase_timer_pkg.sv
// Shared state encoding, default geometry and width helper for the I2C phase timer.
package i2c_phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEF_SIZE   = 16;
  localparam int DEF_PHASES = 4;
  localparam int DEF_BITW   = 4;

  // Phase index width; a 1-bit field is kept even for degenerate phase counts.
  function automatic int phase_w(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

endpackage

// File: rtl/i2c_phase_timer_if.sv
// Control/status bundle between the I2C byte controller (master) and the phase timer (slave).
interface i2c_phase_timer_if
  import i2c_phase_timer_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int PHASES = DEF_PHASES,
  parameter int BITW   = DEF_BITW
);

  localparam int PW = phase_w(PHASES);

  logic [SIZE-1:0] ticks;
  logic            start;
  logic            stop;
  logic            one_shot;
  logic [BITW-1:0] n_bits;
  logic            stretch;

  logic            tick;
  logic [PW-1:0]   phase;
  logic            bit_done;
  logic            done;
  logic            busy;
  logic            stalled;

  modport master (
    output ticks, start, stop, one_shot, n_bits, stretch,
    input  tick, phase, bit_done, done, busy, stalled
  );

  modport slave (
    input  ticks, start, stop, one_shot, n_bits, stretch,
    output tick, phase, bit_done, done, busy, stalled
  );

endinterface

// File: rtl/i2c_phase_timer_tick_gen.sv
// Reloadable prescaler down-counter; zero flag is valid the cycle after the count lands on 0.
// Load beats hold; when neither is asserted the count sticks at 0 until reloaded.
module i2c_phase_timer_tick_gen #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            hold,
  input  logic [SIZE-1:0] ticks,
  output logic            zero
);

  logic [SIZE-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= ticks;
    end else if (!hold && (count != '0)) begin
      count <= count - SIZE'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_phase_timer.sv
// I2C bit-phase sequencer: prescaled phase ticks, bit counting, one-shot runs, SCL stretch hold.
// All outputs registered; stop freezes the run in place, stretch only stalls entry into the SCL-high phase.
module i2c_phase_timer
  import i2c_phase_timer_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int PHASES = DEF_PHASES,
  parameter int BITW   = DEF_BITW
) (
  input logic               clk,
  input logic               rst,
  i2c_phase_timer_if.slave  bus
);

  localparam int            PW         = phase_w(PHASES);
  localparam logic [PW-1:0] LAST_PH    = PW'(PHASES - 1);
  localparam logic [PW-1:0] STRETCH_PH = PW'(PHASES / 2 - 1);

  state_t          state;
  logic [PW-1:0]   phase_q;
  logic [BITW-1:0] bitcnt;
  logic [BITW-1:0] bitcnt_nxt;
  logic [BITW-1:0] nbits_lat;
  logic            os_lat;
  logic            tick_q, bd_q, done_q, busy_q, stalled_q;

  logic zero, do_stop, do_start, run_like, boundary, stall, adv, wrap, last_bit;

  // Stop only matters once a run exists; it outranks a coincident start.
  assign do_stop    = bus.stop && (state != IDLE);
  assign do_start   = bus.start && !do_stop;
  assign run_like   = (state != IDLE) && !bus.stop && !bus.start;
  assign boundary   = run_like && zero;
  assign stall      = boundary && (phase_q == STRETCH_PH) && bus.stretch;
  assign adv        = boundary && !stall;
  assign wrap       = (phase_q == LAST_PH);
  assign bitcnt_nxt = bitcnt + BITW'(1);
  assign last_bit   = os_lat && (bitcnt_nxt == nbits_lat);

  i2c_phase_timer_tick_gen #(
    .SIZE (SIZE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (do_start || adv),
    .hold  (!run_like),
    .ticks (bus.ticks),
    .zero  (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_q   <= '0;
      bitcnt    <= '0;
      nbits_lat <= '0;
      os_lat    <= 1'b0;
      tick_q    <= 1'b0;
      bd_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      bd_q   <= 1'b0;
      done_q <= 1'b0;
      if (do_stop) begin
        state <= PAUSE;
      end else if (do_start) begin
        state     <= RUN;
        phase_q   <= '0;
        bitcnt    <= '0;
        os_lat    <= bus.one_shot;
        nbits_lat <= bus.n_bits;
        busy_q    <= 1'b1;
        stalled_q <= 1'b0;
      end else if (run_like) begin
        state <= RUN;
        if (stall) begin
          stalled_q <= 1'b1;
        end else if (adv) begin
          tick_q    <= 1'b1;
          stalled_q <= 1'b0;
          if (wrap) begin
            phase_q <= '0;
            bd_q    <= 1'b1;
            bitcnt  <= bitcnt_nxt;
            if (last_bit) begin
              done_q <= 1'b1;
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.phase    = phase_q;
  assign bus.bit_done = bd_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.stalled  = stalled_q;

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Scoreboard bench: stimulus queues expected tick events and level checks; one monitor compares them.
module tb_i2c_phase_timer;
  import i2c_phase_timer_pkg::*;

  localparam int SIZE   = 16;
  localparam int PHASES = 4;
  localparam int BITW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_phase_timer_if #(.SIZE(SIZE), .PHASES(PHASES), .BITW(BITW)) bus ();

  i2c_phase_timer #(.SIZE(SIZE), .PHASES(PHASES), .BITW(BITW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int rel;
    int ph;
    bit bd;
    bit dn;
  } ev_t;

  typedef struct {
    int rel;
    int kind;
    int val;
  } lc_t;

  ev_t exp_q[$];
  lc_t lc_q[$];
  int  now     = 0;
  int  t0      = 0;
  int  n_chk   = 0;
  int  n_fail  = 0;
  bit  fin_req = 1'b0;

  always @(posedge clk) now <= now + 1;

  function automatic void exp_tick(input int rel, input int ph, input bit bd, input bit dn);
    ev_t e;
    e.rel = rel; e.ph = ph; e.bd = bd; e.dn = dn;
    exp_q.push_back(e);
  endfunction

  // kind: 0 busy, 1 stalled, 2 phase, 3 tick, 4 every output at reset value
  function automatic void exp_lvl(input int rel, input int kind, input int val);
    lc_t c;
    c.rel = rel; c.kind = kind; c.val = val;
    lc_q.push_back(c);
  endfunction

  task automatic at_rel(input int r);
    while (now - t0 < r) @(negedge clk);
  endtask

  task automatic start_run(input int tk, input bit os, input int nb);
    @(negedge clk);
    bus.ticks    = SIZE'(tk);
    bus.one_shot = os;
    bus.n_bits   = BITW'(nb);
    bus.start    = 1'b1;
    t0 = now + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    int    rel;
    int    act;
    string nm;
    ev_t   e;
    lc_t   c;
    #1;
    rel = now - t0;
    while (exp_q.size() > 0 && exp_q[0].rel < rel) begin
      e = exp_q.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missing_tick rel=%0d: no tick seen, required phase=%0d", e.rel, e.ph);
    end
    if (bus.tick) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick rel=%0d phase=%0d, required no tick", rel, bus.phase);
      end else begin
        e = exp_q.pop_front();
        if (rel != e.rel || int'(bus.phase) != e.ph || bus.bit_done != e.bd || bus.done != e.dn) begin
          n_fail++;
          $display("FAIL tick got rel=%0d phase=%0d bit_done=%0d done=%0d, required rel=%0d phase=%0d bit_done=%0d done=%0d",
                   rel, bus.phase, bus.bit_done, bus.done, e.rel, e.ph, e.bd, e.dn);
        end
      end
    end else if (bus.bit_done || bus.done) begin
      n_chk++; n_fail++;
      $display("FAIL pulse_without_tick rel=%0d bit_done=%0d done=%0d, required 0 0", rel, bus.bit_done, bus.done);
    end
    while (lc_q.size() > 0 && lc_q[0].rel <= rel) begin
      c = lc_q.pop_front();
      n_chk++;
      case (c.kind)
        0:       begin nm = "busy";        act = int'(bus.busy); end
        1:       begin nm = "stalled";     act = int'(bus.stalled); end
        2:       begin nm = "phase";       act = int'(bus.phase); end
        3:       begin nm = "tick";        act = int'(bus.tick); end
        default: begin nm = "reset_state"; act = int'({bus.tick, bus.bit_done, bus.done, bus.busy, bus.stalled, bus.phase}); end
      endcase
      if (c.rel != rel) begin
        n_fail++;
        $display("FAIL %s check for rel=%0d evaluated late at rel=%0d", nm, c.rel, rel);
      end else if (act != c.val) begin
        n_fail++;
        $display("FAIL %s rel=%0d got %0d, required %0d", nm, rel, act, c.val);
      end
    end
    if (fin_req || now > 3000) begin
      if (!fin_req) begin
        n_chk++; n_fail++;
        $display("FAIL timeout at cycle %0d, stimulus did not complete", now);
      end
      n_chk  += exp_q.size() + lc_q.size();
      n_fail += exp_q.size() + lc_q.size();
      if (exp_q.size() + lc_q.size() != 0)
        $display("FAIL leftover expectations: %0d ticks, %0d level checks never reached", exp_q.size(), lc_q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    bus.ticks = '0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.one_shot = 1'b0; bus.n_bits = '0; bus.stretch = 1'b0;
    rst = 1'b1;
    exp_lvl(2, 4, 0);
    at_rel(3);
    rst = 1'b0;

    // Reset mid-run: outputs clear, run is abandoned without done.
    start_run(5, 1'b0, 0);
    exp_lvl(0, 0, 1);
    exp_tick(6, 1, 1'b0, 1'b0);
    exp_lvl(9, 4, 0);
    at_rel(8);
    rst = 1'b1;
    at_rel(10);
    rst = 1'b0;
    at_rel(14);

    // Free-running, ticks=3: tick every 4 cycles, bit_done every 16.
    start_run(3, 1'b0, 0);
    exp_lvl(0, 0, 1);
    for (int k = 1; k <= 8; k++) exp_tick(4 * k, k % 4, (k % 4) == 0, 1'b0);
    exp_lvl(33, 0, 1);
    at_rel(33);
    reset_pulse();
    at_rel(40);

    // One-shot of 2 bits.
    start_run(3, 1'b1, 2);
    for (int k = 1; k <= 8; k++) exp_tick(4 * k, k % 4, (k % 4) == 0, k == 8);
    exp_lvl(31, 0, 1);
    exp_lvl(33, 0, 0);
    exp_lvl(33, 2, 0);
    at_rel(40);

    // One-shot with n_bits=0 runs the full 16 bits.
    start_run(3, 1'b1, 0);
    for (int k = 1; k <= 64; k++) exp_tick(4 * k, k % 4, (k % 4) == 0, k == 64);
    exp_lvl(255, 0, 1);
    exp_lvl(257, 0, 0);
    at_rel(262);

    // Stretch held across the phase 1->2 boundary; ignored at 2->3.
    bus.stretch = 1'b1;
    start_run(3, 1'b0, 0);
    exp_tick(4, 1, 1'b0, 1'b0);
    exp_tick(16, 2, 1'b0, 1'b0);
    exp_tick(20, 3, 1'b0, 1'b0);
    exp_tick(24, 0, 1'b1, 1'b0);
    exp_tick(28, 1, 1'b0, 1'b0);
    exp_lvl(7, 1, 0);
    exp_lvl(8, 1, 1);
    exp_lvl(8, 2, 1);
    exp_lvl(15, 1, 1);
    exp_lvl(16, 1, 0);
    exp_lvl(20, 1, 0);
    at_rel(15);
    bus.stretch = 1'b0;
    at_rel(19);
    bus.stretch = 1'b1;
    at_rel(20);
    bus.stretch = 1'b0;
    at_rel(29);
    reset_pulse();
    at_rel(34);

    // Pause for five edges with counter at 2; start during pause is ignored.
    start_run(7, 1'b0, 0);
    exp_lvl(8, 0, 1);
    exp_lvl(10, 2, 0);
    exp_tick(13, 1, 1'b0, 1'b0);
    exp_tick(21, 2, 1'b0, 1'b0);
    at_rel(5);
    bus.stop = 1'b1;
    at_rel(6);
    bus.start = 1'b1;
    at_rel(7);
    bus.start = 1'b0;
    at_rel(10);
    bus.stop = 1'b0;
    at_rel(22);
    reset_pulse();
    at_rel(26);

    // ticks=0: tick every cycle; restart mid-run; period change waits for next reload.
    start_run(0, 1'b0, 0);
    for (int k = 1; k <= 9; k++) exp_tick(k, k % 4, (k % 4) == 0, 1'b0);
    for (int k = 11; k <= 15; k++) exp_tick(k, (k - 10) % 4, ((k - 10) % 4) == 0, 1'b0);
    exp_tick(25, 2, 1'b0, 1'b0);
    exp_tick(35, 3, 1'b0, 1'b0);
    exp_lvl(10, 2, 0);
    exp_lvl(10, 3, 0);
    exp_lvl(10, 0, 1);
    at_rel(9);
    bus.start = 1'b1;
    at_rel(10);
    bus.start = 1'b0;
    at_rel(14);
    bus.ticks = SIZE'(9);
    at_rel(36);
    reset_pulse();
    at_rel(40);

    fin_req = 1'b1;
  end

endmodule
